// File: rtl/hazard_scoreboard_if.sv
// Decode-stage register-identifier bundle and hazard status returned to the pipeline.
// The master modport drives decode information; the slave modport returns the stall status.
interface hazard_scoreboard_if;
    logic        id_valid;
    logic [2:0]  id_rs;
    logic        id_rs_valid;
    logic [2:0]  id_rt;
    logic        id_rt_valid;
    logic [2:0]  id_rd;
    logic        id_rd_valid;
    logic        id_reg_write;
    logic        flush;
    logic        stall;
    logic [7:0]  inflight_mask;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rs_valid, id_rt, id_rt_valid,
               id_rd, id_rd_valid, id_reg_write, flush,
        input  stall, inflight_mask, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_valid, id_rt, id_rt_valid,
               id_rd, id_rd_valid, id_reg_write, flush,
        output stall, inflight_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: tracks pending register writes between decode
// and write-back and stalls decode while a source register matches one of them.
module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);

    // With the write-back bypass the WB entry never takes part in matching,
    // so only the stages that can hold a pending hazard are stored.
    localparam int N_MATCH = WB_BYPASS ? DEPTH - 1 : DEPTH;

    generate
        if (DEPTH < 2 || DEPTH > 6) begin : g_bad_depth
            $error("hazard_scoreboard: DEPTH must be in 2..6");
        end
    endgenerate

    logic [N_MATCH-1:0] r_v;
    logic [2:0]         r_rd [N_MATCH];
    logic [15:0]        r_stall_count;

    logic [7:0]         w_mask;
    logic               w_hit_rs;
    logic               w_hit_rt;
    logic               w_stall;
    logic               w_load;

    // One-hot OR of every pending destination in the matching set.
    always_comb begin
        w_mask = 8'h00;
        for (int k = 0; k < N_MATCH; k++) begin
            if (r_v[k]) begin
                w_mask[r_rd[k]] = 1'b1;
            end
        end
    end

    assign w_hit_rs = bus.id_rs_valid && w_mask[bus.id_rs];
    assign w_hit_rt = bus.id_rt_valid && w_mask[bus.id_rt];
    assign w_stall  = bus.id_valid && !bus.flush && (w_hit_rs || w_hit_rt);

    // A stalled or squashed decode instruction enters the pipe as a bubble.
    assign w_load = bus.id_valid && bus.id_rd_valid && bus.id_reg_write &&
                    !bus.flush && !w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            // NOTE: this is a small flop array, not a RAM, so every entry takes the async reset.
            for (int k = 0; k < N_MATCH; k++) begin
                r_rd[k] <= 3'b000;
            end
        end else begin
            // NOTE: non-blocking assignments make every entry shift from its pre-edge value.
            r_v[0]  <= w_load;
            r_rd[0] <= w_load ? bus.id_rd : 3'b000;
            for (int k = 1; k < N_MATCH; k++) begin
                r_v[k]  <= r_v[k-1];
                r_rd[k] <= r_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && r_stall_count != 16'hFFFF) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.inflight_mask = w_mask;
    assign bus.stall_count   = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed checks of hazard_scoreboard in three configurations,
// compared against a history-of-writes reference model.
module tb_hazard_scoreboard;

    logic clk;
    logic rst;

    hazard_scoreboard_if ifa ();
    hazard_scoreboard_if ifb ();
    hazard_scoreboard_if ifc ();

    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    hazard_scoreboard #(.DEPTH(6), .WB_BYPASS(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Current decode inputs, mirrored for the model.
    bit t_valid, t_rsv, t_rtv, t_rdv, t_rw, t_fl;
    int t_rs, t_rt, t_rd;

    // hist[m][k]: register written by the instruction that left decode k+1 cycles ago, -1 if none.
    int hist [3][6];
    int mcnt [3];
    int sc   [3];
    int obs_st [3];

    task automatic check(input string tag, input int observed, input int expected);
        n_cmp++;
        if (observed != expected) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int nmatch(input int m);
        case (m)
            0:       return 2;
            1:       return 3;
            default: return 6;
        endcase
    endfunction

    function automatic string cfg_name(input int m);
        case (m)
            0:       return "d3byp";
            1:       return "d3nob";
            default: return "d6nob";
        endcase
    endfunction

    function automatic bit m_hit(input int m, input int r);
        for (int k = 0; k < nmatch(m); k++)
            if (hist[m][k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall(input int m);
        return t_valid && !t_fl && ((t_rsv && m_hit(m, t_rs)) || (t_rtv && m_hit(m, t_rt)));
    endfunction

    function automatic int m_mask(input int m);
        int mk = 0;
        for (int k = 0; k < nmatch(m); k++)
            if (hist[m][k] >= 0) mk |= (1 << hist[m][k]);
        return mk;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            for (int k = 0; k < 6; k++) hist[m][k] = -1;
            mcnt[m] = 0;
        end
    endtask

    task automatic sample(input int m, output int st, output int mk, output int ct);
        case (m)
            0: begin st = int'(ifa.stall); mk = int'(ifa.inflight_mask); ct = int'(ifa.stall_count); end
            1: begin st = int'(ifb.stall); mk = int'(ifb.inflight_mask); ct = int'(ifb.stall_count); end
            default: begin st = int'(ifc.stall); mk = int'(ifc.inflight_mask); ct = int'(ifc.stall_count); end
        endcase
    endtask

    task automatic drive(input bit v, input int rs, input bit rsv, input int rt, input bit rtv,
                         input int rd, input bit rdv, input bit rw, input bit fl);
        t_valid = v; t_rs = rs; t_rsv = rsv; t_rt = rt; t_rtv = rtv;
        t_rd = rd; t_rdv = rdv; t_rw = rw; t_fl = fl;
        ifa.id_valid = v; ifb.id_valid = v; ifc.id_valid = v;
        ifa.id_rs = 3'(rs); ifb.id_rs = 3'(rs); ifc.id_rs = 3'(rs);
        ifa.id_rs_valid = rsv; ifb.id_rs_valid = rsv; ifc.id_rs_valid = rsv;
        ifa.id_rt = 3'(rt); ifb.id_rt = 3'(rt); ifc.id_rt = 3'(rt);
        ifa.id_rt_valid = rtv; ifb.id_rt_valid = rtv; ifc.id_rt_valid = rtv;
        ifa.id_rd = 3'(rd); ifb.id_rd = 3'(rd); ifc.id_rd = 3'(rd);
        ifa.id_rd_valid = rdv; ifb.id_rd_valid = rdv; ifc.id_rd_valid = rdv;
        ifa.id_reg_write = rw; ifb.id_reg_write = rw; ifc.id_reg_write = rw;
        ifa.flush = fl; ifb.flush = fl; ifc.flush = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One decode cycle: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step(input bit do_check);
        bit est [3];
        int st, mk, ct;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            est[m] = m_stall(m);
            sample(m, st, mk, ct);
            obs_st[m] = st;
            sc[m] += st;
            if (do_check) begin
                check({cfg_name(m), " stall"}, st, int'(est[m]));
                check({cfg_name(m), " mask"}, mk, m_mask(m));
                check({cfg_name(m), " count"}, ct, mcnt[m]);
            end
        end
        @(posedge clk);
        for (int m = 0; m < 3; m++) begin
            for (int k = 5; k > 0; k--) hist[m][k] = hist[m][k-1];
            hist[m][0] = (t_valid && t_rdv && t_rw && !t_fl && !est[m]) ? t_rd : -1;
            if (est[m] && mcnt[m] < 65535) mcnt[m]++;
        end
        #1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 8; i++) step(1);
        for (int m = 0; m < 3; m++) sc[m] = 0;
    endtask

    // Producer of r1, `gap` NOPs, then a reader of r1 held long enough to outlast any stall.
    task automatic run_gap(input int gap);
        int base [3];
        drain();
        drive(1, 2, 1, 3, 1, 1, 1, 1, 0);
        step(1);
        nop();
        for (int i = 0; i < gap; i++) step(1);
        drive(1, 1, 1, 1, 1, 2, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(1);
        base[0] = 2; base[1] = 3; base[2] = 6;
        for (int m = 0; m < 3; m++)
            check($sformatf("%s gap%0d stall cycles", cfg_name(m), gap), sc[m],
                  (base[m] - gap > 0) ? base[m] - gap : 0);
    endtask

    initial begin
        int st, mk, ct;
        n_cmp = 0;
        n_bad = 0;
        for (int m = 0; m < 3; m++) sc[m] = 0;
        model_reset();

        // Reset held with a hazard-looking reader in decode.
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 1, 1, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            sample(m, st, mk, ct);
            check({cfg_name(m), " rst stall"}, st, 0);
            check({cfg_name(m), " rst mask"}, mk, 0);
            check({cfg_name(m), " rst count"}, ct, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        run_gap(0);
        run_gap(1);
        run_gap(2);

        // Store reports an Rd field but does not write.
        drain();
        drive(1, 2, 1, 3, 1, 1, 1, 0, 0);
        step(1);
        drive(1, 1, 1, 1, 1, 2, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(1);
        for (int m = 0; m < 3; m++) check({cfg_name(m), " store no stall"}, sc[m], 0);

        // Branch reads rs only after a load-immediate.
        drain();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
        step(1);
        drive(1, 5, 1, 5, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1);
        check("d3byp branch rs stall cycles", sc[0], 2);
        check("d6nob branch rs stall cycles", sc[2], 6);

        // Flush beats a hazard; the older producer stays pending.
        drain();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        step(1);
        drive(1, 3, 1, 0, 0, 4, 1, 1, 1);
        step(1);
        check("d3byp flush stall", obs_st[0], 0);
        drive(1, 3, 1, 0, 0, 4, 1, 1, 0);
        step(1);
        check("d3byp after flush stall", obs_st[0], 1);

        // Own destination equals own source: no self-hazard.
        drain();
        drive(1, 1, 1, 0, 0, 1, 1, 1, 0);
        step(1);
        nop();
        step(1);
        check("d3byp self source", sc[0], 0);

        // Both sources hit; the younger producer decides.
        drain();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        step(1);
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        step(1);
        drive(1, 1, 1, 2, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1);
        check("d3byp rs+rt stall cycles", sc[0], 2);
        check("d6nob rs+rt stall cycles", sc[2], 6);

        // Asynchronous reset in mid-cycle with state pending.
        drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
        step(1);
        drive(1, 6, 1, 6, 1, 6, 1, 1, 0);
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            sample(m, st, mk, ct);
            check({cfg_name(m), " async rst stall"}, st, 0);
            check({cfg_name(m), " async rst mask"}, mk, 0);
            check({cfg_name(m), " async rst count"}, ct, 0);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(1);
        check("d6nob post-reset no hazard", obs_st[2], 0);

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            step(1);
        end

        // Saturation: a self-dependent writer stalls most cycles in every configuration.
        drive(1, 1, 1, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 78000; i++) step(i % 1000 == 0);
        step(1);
        sample(2, st, mk, ct);
        check("d6nob saturated count", ct, 65535);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage RAW hazard detector for the 5-stage WISC pipeline. It consumes the per-instruction source/destination register identifiers and valid flags produced by the decode register-identifier logic. It tracks destinations of instructions in flight between decode and register-file write-back, and asserts a stall when a decode-stage source register matches a pending destination. There is no forwarding; every RAW hazard is resolved by stalling.

## Interface
Parameters:
- DEPTH, 3, number of in-flight stages tracked after decode (EX, MEM, WB); legal range 2–6.
- WB_BYPASS, 1, 1 = register file writes in first half-cycle and reads in second, so the last tracked stage (WB) is excluded from matching.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs  in  3  decode source register s.
- id_rs_valid  in  1  id_rs is read.
- id_rt  in  3  decode source register t.
- id_rt_valid  in  1  id_rt is read.
- id_rd  in  3  decode destination register.
- id_rd_valid  in  1  id_rd field is meaningful.
- id_reg_write  in  1  instruction writes the register file; gates id_rd_valid, e.g. ST reports an Rd field but does not write.
- flush  in  1  decode instruction is squashed this cycle (taken branch/jump).
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- inflight_mask  out  8  bit i = register i has a pending write in a matching stage.
- stall_count  out  16  cycles with stall asserted, saturating.

## Operation
- State: DEPTH entries {v, rd[2:0]}; entry 0 = EX, entry DEPTH-1 = WB.
- Matching set: entries 0..DEPTH-2 if WB_BYPASS=1, else 0..DEPTH-1.
- hit(r) = any entry k in matching set with v_k && rd_k == r.
- All 8 registers, including r0 and r7, are real registers. r0 is not hardwired; no register is exempt from matching.
- stall = id_valid && !flush && ((id_rs_valid && hit(id_rs)) || (id_rt_valid && hit(id_rt))). Purely combinational from state and current inputs.
- Per rising clk:
  - entries k≥1 take entry k-1, unconditionally shifting every cycle, including while stalled.
  - entry 0 loads {1, id_rd} iff id_valid && id_rd_valid && id_reg_write && !flush && !stall. Otherwise entry 0 loads {0, 3'b000} (a bubble).
- Flush squashes only the decode-stage instruction; older entries are untouched.
- An instruction whose destination equals its own source (e.g. ADDI r1,r1,#1) does not hazard on itself; matching uses only older entries.
- inflight_mask: OR over matching-set entries of (v_k ? 1<<rd_k : 0). Combinational.
- stall_count: +1 on each clk edge where stall=1. Holds at 16'hFFFF once reached.

## Timing
- Reset (async, immediate): all entries v=0, rd=0; stall_count=0. Consequently stall=0 and inflight_mask=0 while rst is high, regardless of inputs.
- Reset deasserted mid-sequence: pipeline state is lost, and the first post-reset instruction sees no hazards.
- Stall latency: 0 cycles. stall asserts in the same cycle the dependent instruction is in decode.
- Stall duration, dependent instruction immediately following its producer:
  - WB_BYPASS=1: DEPTH-1 cycles.
  - WB_BYPASS=0: DEPTH cycles.
- Each intervening independent instruction reduces the stall by 1 cycle, to a minimum of 0.
- Simultaneous flush and hazard: flush wins. stall=0 and a bubble enters.
- Both rs and rt hit: stall lasts until the later-retiring (younger) producer leaves the matching set.

## Test plan
- Reset: drive rst=1 with id_valid=1, id_rs=1, id_rs_valid=1 -> stall=0, inflight_mask=8'h00, stall_count=0; assert asynchronously mid-cycle.
- Back-to-back RAW (DEPTH=3, WB_BYPASS=1): ADD r1 then ADD r2,r1,r3 -> stall high exactly 2 cycles; inflight_mask=8'h02 for those cycles; stall_count=2.
- Distance/bypass: ADD r1, NOP, ADD r2,r1,r1 -> 1 stall cycle. Same with WB_BYPASS=0 -> 2 stall cycles. Two NOPs with WB_BYPASS=1 -> 0.
- Non-writers and gating: ST r1 (id_rd_valid=1, id_reg_write=0) then ADD using r1 -> no stall. BEQZ r5 after LBI r5 -> 2 stall cycles via rs only.
- Flush: hazard-inducing instruction in decode with flush=1 -> stall=0, entry 0 becomes bubble. Next cycle the older producer is still matched by a new reader.
- Saturation: force 70000 consecutive stall cycles (hold a reader against a producer that never retires via a test-only long DEPTH=6, or by repeated producers) -> stall_count stops at 16'hFFFF.
